path_sequencer: RTL and testbench

PATH_SEQUENCER -- requirements
Module: path_sequencer

---
 rtl/path_sequencer.sv | 172 +++++++++++++++++
 tb/tb_path_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_sequencer.sv
// path_sequencer -- turn-plan sequencer for a line-following robot.
//
// A plan of 2-bit turn codes (0 straight, 1 right, 2 U-turn, 3 left) is
// written while idle, validated with plan_commit/plan_len, then replayed one
// entry per accepted node_changed pulse once start is seen.
//
// Ports
//   clk_3125KHz   in   sole clock, rising edge
//   rst           in   asynchronous active-high reset
//   plan_wr_en    in   plan memory write strobe (honoured only in IDLE)
//   plan_wr_addr  in   [4:0] write address
//   plan_wr_data  in   [1:0] turn code
//   plan_commit   in   pulse, validates plan_len
//   plan_len      in   [5:0] number of valid entries
//   start         in   level, begins traversal from ARMED
//   clear         in   pulse, abandons the plan (wins over everything else)
//   node_changed  in   pulse from line follower on node exit
//   turn_flag     out  [1:0] turn code for the next node
//   end_path      out  plan exhausted
//   node_idx      out  [5:0] current plan entry
//   busy          out  ARMED or RUN
//   plan_err      out  one-cycle pulse on a rejected commit
//
// Build option
//   PATH_SEQ_LOOP_EN  when defined, the last entry wraps back to entry 0 and
//                     the sequencer stays in RUN forever (end_path never set).
module path_sequencer #(
  parameter int DEPTH   = 32,
  parameter int MIN_GAP = 3125
) (
  input  logic       clk_3125KHz,
  input  logic       rst,
  input  logic       plan_wr_en,
  input  logic [4:0] plan_wr_addr,
  input  logic [1:0] plan_wr_data,
  input  logic       plan_commit,
  input  logic [5:0] plan_len,
  input  logic       start,
  input  logic       clear,
  input  logic       node_changed,
  output logic [1:0] turn_flag,
  output logic       end_path,
  output logic [5:0] node_idx,
  output logic       busy,
  output logic       plan_err
);

  localparam logic [5:0]  DEPTH_L = 6'(DEPTH);
  localparam logic [15:0] GAP_L   = 16'(MIN_GAP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  len_q,   len_d;
  logic [5:0]  idx_q,   idx_d;
  logic [15:0] gap_q,   gap_d;
  logic [1:0]  turn_q,  turn_d;
  logic        end_q,   end_d;
  logic        err_q,   err_d;

  // Full 32-entry array so the 5-bit address never needs narrowing; entries
  // at or beyond DEPTH are simply never written.
  logic [1:0]  mem_q [0:31];

  logic [5:0]  idx_nx;
  logic        accept;

  // Plan memory: no reset, contents survive clear.
  always_ff @(posedge clk_3125KHz) begin
    if (state_q == IDLE && plan_wr_en && ({1'b0, plan_wr_addr} < DEPTH_L))
      mem_q[plan_wr_addr] <= plan_wr_data;
  end

  always_comb begin
    idx_nx  = idx_q + 6'd1;
    // Early pulses are dropped outright, not deferred.
    accept  = (state_q == RUN) && node_changed && (gap_q == 16'd0);

    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    turn_d  = turn_q;
    end_d   = end_q;
    err_d   = 1'b0;

    if (clear) begin
      state_d = IDLE;
      idx_d   = 6'd0;
      turn_d  = 2'd0;
      end_d   = 1'b0;
      gap_d   = 16'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (plan_commit) begin
            if (plan_len >= 6'd1 && plan_len <= DEPTH_L) begin
              len_d   = plan_len;
              state_d = ARMED;
            end else begin
              err_d   = 1'b1;
            end
          end
        end
        ARMED: begin
          if (start) begin
            state_d = RUN;
            idx_d   = 6'd0;
            turn_d  = mem_q[0];
            gap_d   = GAP_L;
          end
        end
        RUN: begin
          if (accept) begin
            gap_d = GAP_L;
            if (idx_nx < len_q) begin
              idx_d  = idx_nx;
              turn_d = mem_q[idx_nx[4:0]];
            end else begin
`ifdef PATH_SEQ_LOOP_EN
              idx_d  = 6'd0;
              turn_d = mem_q[0];
`else
              state_d = DONE;
              idx_d   = len_q;
              turn_d  = 2'd0;
              end_d   = 1'b1;
              gap_d   = 16'd0;
`endif
            end
          end else if (gap_q != 16'd0) begin
            gap_d = gap_q - 16'd1;
          end
        end
        DONE: ;  // hold until clear
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_3125KHz or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= 6'd0;
      idx_q   <= 6'd0;
      gap_q   <= 16'd0;
      turn_q  <= 2'd0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      turn_q  <= turn_d;
      end_q   <= end_d;
      err_q   <= err_d;
    end
  end

  assign turn_flag = turn_q;
  assign end_path  = end_q;
  assign node_idx  = idx_q;
  assign busy      = (state_q == ARMED) || (state_q == RUN);
  assign plan_err  = err_q;

endmodule

// File: tb/tb_path_sequencer.sv
module tb_path_sequencer;
  localparam int DEPTH   = 32;
  localparam int MIN_GAP = 3125;

  logic       clk_3125KHz = 1'b0;
  logic       rst;
  logic       plan_wr_en, plan_commit, start, clear, node_changed;
  logic [4:0] plan_wr_addr;
  logic [1:0] plan_wr_data;
  logic [5:0] plan_len;
  logic [1:0] turn_flag;
  logic       end_path, busy, plan_err;
  logic [5:0] node_idx;

  always #160 clk_3125KHz = ~clk_3125KHz;

  path_sequencer #(.DEPTH(DEPTH), .MIN_GAP(MIN_GAP)) dut (
    .clk_3125KHz (clk_3125KHz),
    .rst         (rst),
    .plan_wr_en  (plan_wr_en),
    .plan_wr_addr(plan_wr_addr),
    .plan_wr_data(plan_wr_data),
    .plan_commit (plan_commit),
    .plan_len    (plan_len),
    .start       (start),
    .clear       (clear),
    .node_changed(node_changed),
    .turn_flag   (turn_flag),
    .end_path    (end_path),
    .node_idx    (node_idx),
    .busy        (busy),
    .plan_err    (plan_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: phase, position in the plan, and clocks elapsed since
  // the last (re)arming of the node acceptance window.
  localparam int P_IDLE = 0, P_ARMED = 1, P_RUN = 2, P_DONE = 3;
  int       m_ph, m_len, m_idx, m_since;
  bit       m_err;
  bit [1:0] m_plan [32];

  task automatic model_reset();
    m_ph = P_IDLE; m_len = 0; m_idx = 0; m_since = 0; m_err = 0;
  endtask

  task automatic model_edge();
    m_err = 0;
    if (rst) begin model_reset(); return; end
    if (m_ph == P_IDLE && plan_wr_en && int'(plan_wr_addr) < DEPTH)
      m_plan[plan_wr_addr] = plan_wr_data;
    if (clear) begin
      m_ph = P_IDLE; m_idx = 0;
    end else begin
      case (m_ph)
        P_IDLE:
          if (plan_commit) begin
            if (int'(plan_len) >= 1 && int'(plan_len) <= DEPTH) begin
              m_len = int'(plan_len); m_ph = P_ARMED;
            end else m_err = 1;
          end
        P_ARMED:
          if (start) begin m_ph = P_RUN; m_idx = 0; m_since = 0; end
        P_RUN: begin
          m_since++;
          // Must be at least MIN_GAP clocks after the window was armed.
          if (node_changed && m_since > MIN_GAP) begin
            m_since = 0;
            if (m_idx + 1 < m_len) m_idx++;
`ifdef PATH_SEQ_LOOP_EN
            else m_idx = 0;
`else
            else m_ph = P_DONE;
`endif
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [10:0] model_vec();
    logic [1:0] t;
    logic [5:0] i;
    t = (m_ph == P_RUN) ? m_plan[m_idx] : 2'd0;
    i = (m_ph == P_RUN) ? 6'(m_idx) : (m_ph == P_DONE) ? 6'(m_len) : 6'd0;
    return {t, (m_ph == P_DONE), i, (m_ph == P_ARMED || m_ph == P_RUN), m_err};
  endfunction

  logic [10:0] dut_vec;
  assign dut_vec = {turn_flag, end_path, node_idx, busy, plan_err};

  task automatic cyc();
    @(posedge clk_3125KHz);
    model_edge();
    @(negedge clk_3125KHz);
    chk("cyc", 32'(dut_vec), 32'(model_vec()));
    plan_wr_en = 0; plan_commit = 0; start = 0; clear = 0; node_changed = 0;
  endtask

  task automatic wr(input int a, input bit [1:0] d);
    plan_wr_en = 1; plan_wr_addr = 5'(a); plan_wr_data = d; cyc();
  endtask

  task automatic fill_random();
    for (int a = 0; a < 32; a++) wr(a, 2'($urandom_range(0, 3)));
  endtask

  task automatic commit(input int len);
    plan_commit = 1; plan_len = 6'(len); cyc();
  endtask

  // Pulse node_changed on the first edge at which it may be accepted.
  task automatic pulse_on_time();
    for (int g = 0; g < MIN_GAP + 10 && m_since < MIN_GAP; g++) cyc();
    node_changed = 1; cyc();
  endtask

  initial begin
    #(320 * 95000);
    $display("FAIL watchdog: simulation budget exceeded");
    $fatal(1);
  end

  initial begin
    rst = 1; plan_wr_en = 0; plan_wr_addr = 0; plan_wr_data = 0; plan_commit = 0;
    plan_len = 0; start = 0; clear = 0; node_changed = 0;
    model_reset();
    #1;
    chk("reset_outs", 32'(dut_vec), 32'd0);
    @(negedge clk_3125KHz); @(negedge clk_3125KHz);
    rst = 0;

    fill_random();

    // Rejected commits.
    commit(0);
    chk("err_len0", 32'(plan_err), 32'd1);
    cyc();
    chk("err_len0_one_cycle", 32'(plan_err), 32'd0);
    commit(33);
    chk("err_len33", 32'(plan_err), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    cyc();

    // Basic traversal {1,3,0}.
    wr(0, 2'd1); wr(1, 2'd3); wr(2, 2'd0);
    commit(3);
    chk("armed_busy", 32'(busy), 32'd1);
    chk("armed_turn", 32'(turn_flag), 32'd0);
    start = 1; cyc();
    chk("t0", 32'({turn_flag, node_idx}), 32'({2'd1, 6'd0}));
    pulse_on_time();
    chk("t1", 32'({turn_flag, node_idx}), 32'({2'd3, 6'd1}));
    pulse_on_time();
    chk("t2", 32'({turn_flag, node_idx}), 32'({2'd0, 6'd2}));
    pulse_on_time();
`ifdef PATH_SEQ_LOOP_EN
    chk("wrap", 32'({turn_flag, end_path, node_idx}), 32'({2'd1, 1'b0, 6'd0}));
`else
    chk("done", 32'({turn_flag, end_path, node_idx, busy}), 32'({2'd0, 1'b1, 6'd3, 1'b0}));
    for (int k = 0; k < 5; k++) begin
      start = 1; node_changed = 1; cyc();
    end
    chk("done_hold", 32'({end_path, node_idx}), 32'({1'b1, 6'd3}));
`endif
    clear = 1; cyc();
    chk("clear_outs", 32'(dut_vec), 32'd0);

    // Gap enforcement, including one clock too early.
    commit(3); start = 1; cyc();
    pulse_on_time();
    for (int k = 0; k < 9; k++) cyc();
    node_changed = 1; cyc();
    chk("gap_10clk", 32'(node_idx), 32'd1);
    for (int g = 0; g < MIN_GAP + 10 && m_since < MIN_GAP - 1; g++) cyc();
    node_changed = 1; cyc();
    chk("early_by_one", 32'(node_idx), 32'd1);
    node_changed = 1; cyc();
    chk("on_time", 32'(node_idx), 32'd2);

    // clear beats a simultaneous, otherwise acceptable, node pulse.
    for (int g = 0; g < MIN_GAP + 10 && m_since < MIN_GAP; g++) cyc();
    clear = 1; node_changed = 1; cyc();
    chk("clear_vs_node", 32'({turn_flag, node_idx, busy}), 32'd0);

    // Asynchronous reset mid-RUN at entry 2.
    commit(3); start = 1; cyc();
    pulse_on_time(); pulse_on_time();
    chk("pre_rst_idx", 32'(node_idx), 32'd2);
    for (int k = 0; k < 7; k++) cyc();
    #40 rst = 1;
    #1 chk("rst_async", 32'(dut_vec), 32'd0);
    model_reset();
    @(posedge clk_3125KHz); @(negedge clk_3125KHz);
    rst = 0;
    for (int k = 0; k < 3; k++) begin start = 1; cyc(); end
    chk("start_no_commit", 32'(busy), 32'd0);
    fill_random();

    // Longest legal plan is accepted.
    commit(32);
    chk("len32_ok", 32'({busy, plan_err}), 32'({1'b1, 1'b0}));
    clear = 1; cyc();

    // Single-entry plan.
    wr(0, 2'd3);
    commit(1); start = 1; cyc();
    chk("len1_t0", 32'(turn_flag), 32'd3);
    pulse_on_time();
`ifdef PATH_SEQ_LOOP_EN
    chk("len1_wrap", 32'({turn_flag, end_path, node_idx}), 32'({2'd3, 1'b0, 6'd0}));
`else
    chk("len1_done", 32'({end_path, node_idx}), 32'({1'b1, 6'd1}));
`endif
    clear = 1; cyc();

`ifdef PATH_SEQ_LOOP_EN
    wr(0, 2'd2); wr(1, 2'd1);
    commit(2); start = 1; cyc();
    chk("loop_t0", 32'(turn_flag), 32'd2);
    pulse_on_time(); chk("loop_t1", 32'(turn_flag), 32'd1);
    pulse_on_time(); chk("loop_t2", 32'(turn_flag), 32'd2);
    pulse_on_time(); chk("loop_t3", 32'({turn_flag, end_path}), 32'({2'd1, 1'b0}));
    clear = 1; cyc();
`endif

    // Randomized episodes checked cycle by cycle against the model.
    for (int ep = 0; ep < 3; ep++) begin
      fill_random();
      if ($urandom_range(0, 1) == 1) commit($urandom_range(0, 1) == 1 ? 0 : 33 + $urandom_range(0, 30));
      commit($urandom_range(1, 4));
      for (int k = $urandom_range(0, 5); k > 0; k--) cyc();
      start = 1; cyc();
      for (int c = 0; c < 9000 && m_ph != P_DONE; c++) begin
        node_changed = ($urandom_range(0, 299) == 0);
        start        = 1'($urandom_range(0, 1));
        clear        = ($urandom_range(0, 4999) == 0);
        plan_wr_en   = 1'($urandom_range(0, 1));
        plan_wr_addr = 5'($urandom_range(0, 31));
        plan_wr_data = 2'($urandom_range(0, 3));
        plan_commit  = ($urandom_range(0, 999) == 0);
        plan_len     = 6'($urandom_range(0, 63));
        cyc();
      end
      clear = 1; cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
